mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 8, word address width (256 locations).
REQ-002 Parameter DW, default 32, data word width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0 / req1  input  1  access request from port 0 (load/store unit) / port 1 (DMA/debug).
REQ-006 we0 / we1  input  1  1 = write, 0 = read; held stable with req until grant.
REQ-007 addr0 / addr1  input  AW  word address; held stable with req until grant.
REQ-008 wdata0 / wdata1  input  DW  write data; held stable with req until grant.
REQ-009 gnt0 / gnt1  output  1  one-cycle pulse: request accepted and memory access performed this cycle.
REQ-010 rvalid0 / rvalid1  output  1  one-cycle pulse: rdata of that port is valid.
REQ-011 rdata0 / rdata1  output  DW  registered read data; holds last value until next read response to that port.
REQ-012 mem_a  output  AW  address to data memory.
REQ-013 mem_din  output  DW  write data to data memory.
REQ-014 mem_mread / mem_mwrite  output  1  memory read / write enables.
REQ-015 mem_dout  input  DW  combinational read data from data memory (0 when mem_mread low).

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-017 Requests SHALL be sampled only in IDLE; if any req is high, the winner's we/addr/wdata SHALL be registered and the FSM SHALL go to ACCESS.
REQ-018 In ACCESS, mem_a / mem_din SHALL come from the registered request, and exactly one of mem_mread / mem_mwrite SHALL be high per the registered we.
REQ-019 In ACCESS, the winner's gnt SHALL be high for exactly that cycle; the other gnt SHALL stay low.
REQ-020 Write in ACCESS: memory is written at the closing edge, and the FSM SHALL return to IDLE (write = 2 cycles req-to-IDLE).
REQ-021 Read in ACCESS: mem_dout SHALL be captured into the winner's rdata at the closing edge, and the FSM SHALL go to RESP.
REQ-022 In RESP, the winner's rvalid SHALL be high for one cycle; the FSM SHALL then go to IDLE (read = 3 cycles; rvalid one cycle after gnt).
REQ-023 The loser's request SHALL remain pending and be re-arbitrated at the next IDLE; no request is dropped.
REQ-024 Outside ACCESS, mem_mread, mem_mwrite, mem_a and mem_din SHALL be 0.
REQ-025 A req deasserted before its gnt SHALL be treated as withdrawn; no access is performed for it.
REQ-026 The arbiter SHALL keep a last-granted pointer, updated on every grant.

Reset
REQ-027 While rst is high, the FSM SHALL enter IDLE at the next edge, and gnt*, rvalid*, rdata*, mem_* SHALL be 0.
REQ-028 The last-granted pointer SHALL reset to port 1, so port 0 wins the first tie.
REQ-029 mem_mwrite SHALL be gated by !rst so that a reset asserted during ACCESS performs no memory write; any in-flight read response SHALL be discarded.

Configuration
REQ-030 With macro MEM_ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin, to the port not last granted.
REQ-031 Without MEM_ARB_RR_EN, port 0 SHALL always win ties (fixed priority); the pointer MAY be omitted.

Verification
REQ-032 Port 0 write, addr 0x05, data 0xDEADBEEF: gnt0 pulses 1 cycle after req, mem_mwrite is high that one cycle, mem[5]=0xDEADBEEF.
REQ-033 Port 1 read of addr 0x40 with initial content 0x00000010: gnt1 at cycle 1, rvalid1 at cycle 2, rdata1=0x00000010.
REQ-034 req0 and req1 reads held high continuously, RR_EN defined: grants alternate 0,1,0,1; undefined: port 0 granted on every arbitration and gnt1 never fires.
REQ-035 Port 0 write 0x1234 to addr 3, then port 1 read of addr 3: rdata1=0x00001234.
REQ-036 rst asserted during a write ACCESS to addr 7: mem[7] unchanged, all outputs 0 next cycle, FSM in IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port data memory (IDLE -> ACCESS [-> RESP]).
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise port 0 always wins ties.
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_din,
  output logic          mem_mread,
  output logic          mem_mwrite,
  input  logic [DW-1:0] mem_dout
);

  localparam int NP = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            win_q, win_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic [NP-1:0]   req_v;
  logic [NP-1:0]   we_v;
  logic [AW-1:0]   addr_v  [NP];
  logic [DW-1:0]   wdata_v [NP];
  logic [DW-1:0]   rdata_q [NP];
  logic [DW-1:0]   rdata_v [NP];
  logic [NP-1:0]   gnt_v;
  logic [NP-1:0]   rvalid_v;

  logic            pick;
  logic            win_req;
  logic            access_ok;
  logic            rd_capture;

  assign req_v      = {req1, req0};
  assign we_v       = {we1, we0};
  assign addr_v[0]  = addr0;
  assign addr_v[1]  = addr1;
  assign wdata_v[0] = wdata0;
  assign wdata_v[1] = wdata1;

`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;

  // On a tie the port that was not granted last time wins.
  assign pick   = (req0 && req1) ? ~last_q : ~req0;
  assign last_d = access_ok ? win_q : last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign pick = ~req0;
`endif

  // A winner that dropped its request before being granted is dropped, no access.
  assign win_req    = req_v[win_q];
  assign access_ok  = (state_q == ACCESS) && win_req;
  assign rd_capture = access_ok && !we_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (|req_v) begin
          state_d = ACCESS;
          win_d   = pick;
          we_d    = we_v[pick];
          addr_d  = addr_v[pick];
          wdata_d = wdata_v[pick];
        end
      end
      ACCESS:  state_d = rd_capture ? RESP : IDLE;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Every output is forced to 0 while rst is high, including a write already in ACCESS.
  always_comb begin
    mem_a      = '0;
    mem_din    = '0;
    mem_mread  = 1'b0;
    mem_mwrite = 1'b0;
    gnt_v      = '0;
    rvalid_v   = '0;
    if (!rst) begin
      if (access_ok) begin
        mem_a        = addr_q;
        mem_din      = wdata_q;
        mem_mread    = !we_q;
        mem_mwrite   = we_q;
        gnt_v[win_q] = 1'b1;
      end
      if (state_q == RESP) begin
        rvalid_v[win_q] = 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NP; gi++) begin : g_port
      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_q[gi] <= '0;
        end else if (rd_capture && (win_q == 1'(gi))) begin
          rdata_q[gi] <= mem_dout;
        end
      end
      assign rdata_v[gi] = rst ? '0 : rdata_q[gi];
    end
  endgenerate

  assign gnt0    = gnt_v[0];
  assign gnt1    = gnt_v[1];
  assign rvalid0 = rvalid_v[0];
  assign rvalid1 = rvalid_v[1];
  assign rdata0  = rdata_v[0];
  assign rdata1  = rdata_v[1];

endmodule
